// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: host-write, status and TX-parallel signals of uart_tx_queue.
// The slave modport is the queue itself; the master modport is the environment,
// i.e. the host writer together with the UART transmitter it feeds.
// Optional macro UART_TXQ_RETRY_EN adds the retry_count status signal.
interface uart_tx_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // host write side and queue status
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  overflow;
    logic                  tx_timeout;

    // transmitter parallel interface
    logic [DATA_WIDTH-1:0] P_DATA_IN_TX;
    logic                  DATA_VALID_TX;
    logic                  busy_flag_TX;
    logic                  data_lost_TX;

`ifdef UART_TXQ_RETRY_EN
    logic [7:0]            retry_count;

    modport slave (
        input  wr_en, wr_data, busy_flag_TX, data_lost_TX,
        output fifo_full, fifo_empty, fifo_count, overflow, tx_timeout,
               P_DATA_IN_TX, DATA_VALID_TX, retry_count
    );

    modport master (
        output wr_en, wr_data, busy_flag_TX, data_lost_TX,
        input  fifo_full, fifo_empty, fifo_count, overflow, tx_timeout,
               P_DATA_IN_TX, DATA_VALID_TX, retry_count
    );
`else
    modport slave (
        input  wr_en, wr_data, busy_flag_TX, data_lost_TX,
        output fifo_full, fifo_empty, fifo_count, overflow, tx_timeout,
               P_DATA_IN_TX, DATA_VALID_TX
    );

    modport master (
        output wr_en, wr_data, busy_flag_TX, data_lost_TX,
        input  fifo_full, fifo_empty, fifo_count, overflow, tx_timeout,
               P_DATA_IN_TX, DATA_VALID_TX
    );
`endif

endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue in front of a UART transmitter.
// Host words are buffered in a synchronous FIFO and launched one at a time on
// P_DATA_IN_TX / DATA_VALID_TX, paced by busy_flag_TX. The head word stays in
// the FIFO until the transmitter acknowledges it (busy rises) or the
// acknowledge timer expires, so fifo_count includes the word in flight.
// Optional feature, macro UART_TXQ_RETRY_EN: a word reported lost, or one that
// times out, is kept and relaunched; retry_count tracks the relaunches.
module uart_tx_queue #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input logic            tx_clk,
    input logic            rst,     // asynchronous, active low
    uart_tx_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_queue: DEPTH must be a power of two and at least 2");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
        $error("uart_tx_queue: ACK_TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,       // waiting for a queued word and an idle transmitter
        LAUNCH,     // strobe cycle, DATA_VALID_TX is high
        WAIT_ACK,   // waiting for busy_flag_TX to confirm the word was taken
        WAIT_DONE   // transmitter busy with our word
    } state_t;

    state_t                state;
    logic [7:0]            timer;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_word;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  timeout_q;
    logic                  overflow_q;

`ifdef UART_TXQ_RETRY_EN
    logic [7:0]            retry_q;
    logic                  relaunch_q;   // next launch repeats a lost/timed-out word
`else
    // Loss reports only matter when relaunching is built in.
    logic                  lost_unused;
    assign lost_unused = bus.data_lost_TX;
`endif

    // Full/empty come from the registered count, i.e. the pre-edge occupancy,
    // so a write that meets a pop while full is still dropped.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push      = bus.wr_en && !full;
    assign head_word = mem[rd_ptr];

    // Pop the head only on acknowledge, or on timeout when relaunch is not built in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        pop = 1'b0;
        if (state == WAIT_ACK) begin
            if (bus.busy_flag_TX) begin
                pop = 1'b1;
            end
`ifndef UART_TXQ_RETRY_EN
            else if (timer == TIMEOUT_LAST) begin
                pop = 1'b1;
            end
`endif
        end
    end

    // FIFO storage write port.
    always_ff @(posedge tx_clk) begin
        // NOTE: the storage array has no reset; pointers and count define which
        // entries are valid, so clearing the array would only cost reset fan-out.
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge tx_clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Launch FSM with registered strobe, data, timeout and retry outputs.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef UART_TXQ_RETRY_EN
            retry_q    <= '0;
            relaunch_q <= 1'b0;
`endif
        end else begin
            // Strobe and timeout are single-cycle pulses unless set below.
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty && !bus.busy_flag_TX) begin
                        data_q  <= head_word;
                        valid_q <= 1'b1;
                        state   <= LAUNCH;
`ifdef UART_TXQ_RETRY_EN
                        if (relaunch_q) begin
                            relaunch_q <= 1'b0;
                            if (retry_q != 8'hFF) begin
                                retry_q <= retry_q + 1'b1;
                            end
                        end
`endif
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.busy_flag_TX) begin
                        state <= WAIT_DONE;
`ifdef UART_TXQ_RETRY_EN
                        retry_q <= '0;
`endif
                    end
`ifdef UART_TXQ_RETRY_EN
                    else if (bus.data_lost_TX) begin
                        relaunch_q <= 1'b1;
                        state      <= IDLE;
                    end
`endif
                    else if (timer == TIMEOUT_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
`ifdef UART_TXQ_RETRY_EN
                        relaunch_q <= 1'b1;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.busy_flag_TX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_full     = full;
    assign bus.fifo_empty    = empty;
    assign bus.fifo_count    = count;
    assign bus.overflow      = overflow_q;
    assign bus.tx_timeout    = timeout_q;
    assign bus.P_DATA_IN_TX  = data_q;
    assign bus.DATA_VALID_TX = valid_q;
`ifdef UART_TXQ_RETRY_EN
    assign bus.retry_count   = retry_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed scenarios followed by randomized traffic, every
// cycle compared against a word-queue reference model that tracks launches
// and acknowledge windows by edge timestamps.
module tb_uart_tx_queue;

    localparam int DW          = 8;
    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 15;
`ifdef UART_TXQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic tx_clk = 1'b0;
    logic rst    = 1'b0;

    uart_tx_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    uart_tx_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .tx_clk(tx_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 tx_clk = ~tx_clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned mq[$];       // words accepted and not yet removed
    int           k;           // edges since start
    bit           in_flight;   // a word has been offered and awaits acknowledge
    bit           draining;    // transmitter is busy with an acknowledged word
    int           launch_k;    // edge at which the current word was offered
    int           ready_k;     // first edge at which a new launch may happen
    bit           retry_pend;
    int           exp_retry;
    bit           e_valid, e_tmo, e_ovf;
    logic [7:0]   e_data;
    bit           have_last;
    int           last_k;

    task automatic model_reset();
        mq.delete();
        in_flight  = 0;
        draining   = 0;
        ready_k    = 0;
        retry_pend = 0;
        exp_retry  = 0;
        e_valid    = 0;
        e_tmo      = 0;
        e_ovf      = 0;
        e_data     = '0;
        have_last  = 0;
    endtask

    // Apply one clock edge's worth of rules to the model, using pre-edge inputs.
    task automatic model_edge(input bit wr, input logic [7:0] d, input bit busy, input bit lost);
        int size_pre;
        bit do_pop;
        size_pre = mq.size();
        k++;
        e_valid  = 0;
        e_tmo    = 0;
        e_ovf    = wr && (size_pre == DEPTH);
        do_pop   = 0;
        if (in_flight) begin
            // acknowledge window opens two edges after the offer
            if (k >= launch_k + 2) begin
                if (busy) begin
                    do_pop    = 1;
                    in_flight = 0;
                    draining  = 1;
                    exp_retry = 0;
                end else if (RETRY && lost) begin
                    in_flight  = 0;
                    ready_k    = k + 1;
                    retry_pend = 1;
                end else if (k == launch_k + 2 + ACK_TIMEOUT) begin
                    e_tmo      = 1;
                    do_pop     = !RETRY;
                    in_flight  = 0;
                    ready_k    = k + 1;
                    retry_pend = RETRY;
                end
            end
        end else if (draining) begin
            if (!busy) begin
                draining = 0;
                ready_k  = k + 1;
            end
        end else if (k >= ready_k && size_pre > 0 && !busy) begin
            e_valid   = 1;
            e_data    = mq[0];
            in_flight = 1;
            launch_k  = k;
            if (retry_pend) begin
                retry_pend = 0;
                if (exp_retry < 255) exp_retry++;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (wr && size_pre < DEPTH) mq.push_back(d);
    endtask

    task automatic compare_all();
        check("DATA_VALID_TX", 32'(bus.DATA_VALID_TX), 32'(e_valid));
        check("P_DATA_IN_TX", 32'(bus.P_DATA_IN_TX), 32'(e_data));
        check("fifo_count", 32'(bus.fifo_count), mq.size());
        check("fifo_full", 32'(bus.fifo_full), 32'(mq.size() == DEPTH));
        check("fifo_empty", 32'(bus.fifo_empty), 32'(mq.size() == 0));
        check("overflow", 32'(bus.overflow), 32'(e_ovf));
        check("tx_timeout", 32'(bus.tx_timeout), 32'(e_tmo));
`ifdef UART_TXQ_RETRY_EN
        check("retry_count", 32'(bus.retry_count), exp_retry);
`else
        if (bus.DATA_VALID_TX === 1'b1) begin
            if (have_last) check("launch_gap_ge4", 32'((k - last_k) >= 4), 1);
            have_last = 1;
            last_k    = k;
        end
`endif
    endtask

    // ---------------- transmitter model ----------------
    // modes: 0 = raise busy, 1 = never respond, 2 = report the word lost
    int tx_wait, busy_left, fb_left;
    int ack_delay, busy_len, tx_mode, cur_mode, shot_mode;
    bit shot_armed, tx_random, force_busy;

    task automatic tx_reset();
        tx_wait    = 0;
        busy_left  = 0;
        fb_left    = 0;
        force_busy = 0;
        shot_armed = 0;
        bus.busy_flag_TX = 1'b0;
        bus.data_lost_TX = 1'b0;
    endtask

    task automatic tx_observe();
        if (bus.DATA_VALID_TX === 1'b1) begin
            if (tx_random) begin
                ack_delay = $urandom_range(1, 4);
                busy_len  = $urandom_range(1, 6);
                cur_mode  = ($urandom_range(99) < 70) ? 0 : (($urandom_range(99) < 30) ? 1 : 2);
            end else if (shot_armed) begin
                cur_mode   = shot_mode;
                shot_armed = 0;
            end else begin
                cur_mode = tx_mode;
            end
            tx_wait = ack_delay;
        end
    endtask

    task automatic drive_tx(output bit busy, output bit lost);
        lost = 0;
        if (tx_wait > 0) begin
            tx_wait--;
            if (tx_wait == 0) begin
                if (cur_mode == 2) lost = 1;
                else if (cur_mode == 0) busy_left = busy_len;
            end
        end
        busy = force_busy || (busy_left > 0);
        if (busy_left > 0) busy_left--;
        bus.busy_flag_TX = busy;
        bus.data_lost_TX = lost;
    endtask

    // One clock: drive at the falling edge, model the rising edge, then compare.
    task automatic step(input bit wr, input logic [7:0] d);
        bit b, l;
        bus.wr_en   = wr;
        bus.wr_data = d;
        drive_tx(b, l);
        model_edge(wr, d, b, l);
        @(posedge tx_clk);
        @(negedge tx_clk);
        compare_all();
        tx_observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((mq.size() != 0 || in_flight || draining) && guard < 2000) begin
            step(1'b0, 8'h00);
            guard++;
        end
        if (guard >= 2000) check("drain_bound", 32'(bus.fifo_count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        k         = 0;
        tx_random = 0;
        tx_mode   = 0;
        ack_delay = 2;
        busy_len  = 3;
        cur_mode  = 0;
        shot_mode = 0;
        tx_reset();
        model_reset();
        repeat (3) @(negedge tx_clk);
        rst = 1'b1;
        compare_all();                         // reset state

        // single word, TX raises busy two cycles after the strobe
        step(1'b1, 8'hA5);
        idle(40);

        // fill with busy held high, then overflow with 0xFF
        force_busy = 1;
        step(1'b0, 8'h00);
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i));
        step(1'b1, 8'hFF);
        idle(3);
        force_busy = 0;
        ack_delay  = 2;
        busy_len   = 2;
        drain();

        // launch waits for busy to fall
        force_busy = 1;
        step(1'b1, 8'h3C);
        idle(5);
        force_busy = 0;
        drain();

        // transmitter never responds to the first offer: timeout
        shot_mode  = 1;
        shot_armed = 1;
        step(1'b1, 8'h55);
        idle(25);
        drain();

        // transmitter reports the first offer lost (ignored unless retry is built in)
        shot_mode  = 2;
        shot_armed = 1;
        step(1'b1, 8'h77);
        idle(30);
        drain();

        // asynchronous reset while the transmitter is busy, words queued behind
        busy_len = 20;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h90 + i));
        for (int i = 0; i < 50 && !draining; i++) step(1'b0, 8'h00);
        check("in_wait_done_cnt", 32'(bus.fifo_count), 5);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", 32'(bus.DATA_VALID_TX), 0);
        check("rst_data", 32'(bus.P_DATA_IN_TX), 0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_empty", 32'(bus.fifo_empty), 1);
        check("rst_full", 32'(bus.fifo_full), 0);
        check("rst_timeout", 32'(bus.tx_timeout), 0);
        bus.wr_en = 1'b0;
        tx_reset();
        model_reset();
        @(posedge tx_clk);
        @(negedge tx_clk);
        rst = 1'b1;
        compare_all();
        idle(10);

        // randomized traffic with a randomized transmitter
        busy_len  = 3;
        tx_random = 1;
        begin
            int wr_pct;
            wr_pct = 40;
            for (int i = 0; i < 2500; i++) begin
                if (i % 200 == 0) wr_pct = (i % 600 == 0) ? 90 : ((i % 400 == 0) ? 10 : 40);
                if (fb_left > 0) fb_left--;
                else if ($urandom_range(99) < 1) fb_left = $urandom_range(1, 8);
                force_busy = (fb_left > 0);
                step(($urandom_range(99) < wr_pct), 8'($urandom));
            end
        end
        force_busy = 0;
        fb_left    = 0;
        drain();
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
